execute_cycle: RTL and testbench
================================

# execute_cycle

Execute stage of the five-stage RV32IM pipeline. Takes the decoded ID/EX operands and controls, applies forwarding, runs the single-cycle ALU and branch compare, and runs multi-cycle RV32M multiply/divide through an internal FSM that stalls the front end. It registers the EX/MEM pipeline register that the memory stage consumes (RegWriteM, MemWriteM, ResultSrcM, RD_M, funct3M, PCPlus4M, WriteDataM, ALU_ResultM).

## Interface
- No parameters; data width is fixed at 32.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, MulDivE  in  1 each  decoded controls
- ALUControlE  in  4  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass B; others give 0
- funct3E  in  3  branch condition, load/store size, or M-op select
- RD_E  in  5  destination register
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  in  32 each  operands and PC values
- ForwardAE, ForwardBE  in  2 each  00 register file, 01 ResultW, 10 ALU_ResultM, 11 register file
- ResultW  in  32  write-back result for forwarding
- PCSrcE  out  1  redirect fetch: (BranchE & taken) | JumpE
- PCTargetE  out  32  PCE + ImmExtE
- BusyE  out  1  stall request to hazard unit
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls
- RD_M  out  5; funct3M  out  3; PCPlus4M, WriteDataM, ALU_ResultM  out  32 each  registered stage outputs

## Operation
- SrcA = forwarded A; WriteData = forwarded B; SrcB = ALUSrcE ? ImmExtE : forwarded B.
- Shifts use SrcB[4:0]; slt signed, sltu unsigned; add/sub wrap modulo 2^32.
- Branch taken per funct3E: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu (on forwarded A/B); other codes never taken.
- MulDivE=1 selects M-op by funct3E: 000 MUL low, 001 MULH s×s, 010 MULHSU s×u, 011 MULHU u×u (upper 32 bits), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE, MulDivE=0: ALU path, BusyE=0.
  - IDLE, MulDivE=1: capture forwarded A/B, funct3E, controls; BusyE=1; go MUL (funct3E[2]=0) or DIV.
  - MUL: register 64-bit product from captured operands; BusyE=1; go DONE.
  - DIV: radix-2 restoring, one quotient bit per cycle on magnitudes, 5-bit counter 31→0; BusyE=1; go DONE after 32nd iteration; sign fix-up applied at DONE.
  - DONE: BusyE=0; EX/MEM loads M-op result; go IDLE.
- Divide-by-zero: quotient 0xFFFFFFFF, remainder = dividend. Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- Operands captured at accept because forwarding sources change during the stall.
- While BusyE=1 the EX/MEM register loads a bubble: RegWriteM=MemWriteM=ResultSrcM=0, other fields don't-care but RD_M=0.
- PCSrcE forced 0 for M-ops.

## Timing
- Reset: every EX/MEM output 0, FSM to IDLE, divider counter 0; reset mid-operation abandons the M-op with no result written.
- ALU ops: result in EX/MEM one edge after presentation; PCSrcE/PCTargetE/BusyE combinational same cycle.
- MUL*: accept cycle + MUL + DONE = 3 cycles in EX, BusyE high 2 cycles.
- DIV*/REM*: accept + 32 DIV + DONE = 34 cycles in EX, BusyE high 33 cycles.
- Hazard unit holds E-stage inputs stable while BusyE=1; in DONE the held inputs still show MulDivE=1 and must not restart the FSM.
- Back-to-back M-ops: second accepted in the IDLE cycle after DONE.

## Test plan
- Reset held 2 cycles with garbage inputs -> all M outputs 0, BusyE 0; release, add 5+7 -> ALU_ResultM=12, RegWriteM follows RegWriteE.
- Forwarding: ForwardAE=10, ALU_ResultM=0x10, ImmExtE=4, ALUSrcE=1 add -> ALU_ResultM=0x14; sra 0x80000000 by 4 -> 0xF8000000.
- Branch blt, A=-1, B=1, PCE=0x100, ImmExtE=0x20 -> PCSrcE=1, PCTargetE=0x120; bltu same operands -> PCSrcE=0.
- MULH 0xFFFFFFFF×0xFFFFFFFF -> BusyE high exactly 2 cycles, bubbles in M, then ALU_ResultM=0; MULHU same -> 0xFFFFFFFE.
- DIV -7/2 -> quotient 0xFFFFFFFD after 33 busy cycles; REM -> 0xFFFFFFFF; DIVU x/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
- rst asserted at DIV iteration 10 -> next cycle IDLE, BusyE 0, M outputs 0; following ALU op completes normally.

Source files
------------

// File: rtl/execute_cycle_if.sv
// execute_cycle_if
//   Bundles the ID/EX inputs of the execute stage and everything it returns
//   (fetch redirect, stall request, EX/MEM register contents).
//   slave  : the execute stage itself (consumes ID/EX, drives EX/MEM)
//   master : whoever presents ID/EX and observes EX/MEM (pipeline / bench)
interface execute_cycle_if;
   // ID/EX side
   logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, MulDivE;
   logic [3:0]  ALUControlE;
   logic [2:0]  funct3E;
   logic [4:0]  RD_E;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ResultW;
   // execute-stage outputs
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        BusyE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [2:0]  funct3M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

   modport slave (
      input  RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, MulDivE,
      input  ALUControlE, funct3E, RD_E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
      input  ForwardAE, ForwardBE, ResultW,
      output PCSrcE, PCTargetE, BusyE,
      output RegWriteM, MemWriteM, ResultSrcM, RD_M, funct3M,
      output PCPlus4M, WriteDataM, ALU_ResultM
   );

   modport master (
      output RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, MulDivE,
      output ALUControlE, funct3E, RD_E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
      output ForwardAE, ForwardBE, ResultW,
      input  PCSrcE, PCTargetE, BusyE,
      input  RegWriteM, MemWriteM, ResultSrcM, RD_M, funct3M,
      input  PCPlus4M, WriteDataM, ALU_ResultM
   );
endinterface

// File: rtl/execute_cycle.sv
// execute_cycle
//   Execute stage of the RV32IM pipeline: operand forwarding, single-cycle
//   ALU and branch compare, multi-cycle multiply / restoring divide, and the
//   EX/MEM pipeline register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : execute_cycle_if.slave (ID/EX inputs, redirect, BusyE, EX/MEM outputs)
module execute_cycle (
   input  logic            clk,
   input  logic            rst,
   execute_cycle_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   // M-op operands and controls captured at accept; forwarding sources move on during the stall
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [2:0]  f3_q, f3_d;
   logic        rw_q, rw_d, mw_q, mw_d, rs_q, rs_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] pc4_q, pc4_d;
   logic [63:0] prod_q, prod_d;
   logic [32:0] rem_q, rem_d;      // bit 32 stays 0; kept so the trial subtract is full width
   logic [31:0] quo_q, quo_d, dvs_q, dvs_d;
   // EX/MEM register
   logic        regwrite_m_q, regwrite_m_d, memwrite_m_q, memwrite_m_d, resultsrc_m_q, resultsrc_m_d;
   logic [4:0]  rd_m_q, rd_m_d;
   logic [2:0]  funct3_m_q, funct3_m_d;
   logic [31:0] pcplus4_m_q, pcplus4_m_d, writedata_m_q, writedata_m_d, alu_result_m_q, alu_result_m_d;

   logic [31:0] src_a, fwd_b, src_b, alu_res, a_mag, b_mag, mop_res, q_fix, r_fix;
   logic [63:0] a64, b64;
   logic [33:0] shifted, diff;
   logic        taken, busy, div_signed;

   // Forwarding muxes (00 and 11 both select the register file)
   always_comb begin
      src_a = bus.RD1E;
      fwd_b = bus.RD2E;
      case (bus.ForwardAE)
         2'b01:   src_a = bus.ResultW;
         2'b10:   src_a = alu_result_m_q;
         default: src_a = bus.RD1E;
      endcase
      case (bus.ForwardBE)
         2'b01:   fwd_b = bus.ResultW;
         2'b10:   fwd_b = alu_result_m_q;
         default: fwd_b = bus.RD2E;
      endcase
      src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;
   end

   always_comb begin
      alu_res = 32'd0;
      case (bus.ALUControlE)
         4'd0:    alu_res = src_a + src_b;
         4'd1:    alu_res = src_a - src_b;
         4'd2:    alu_res = src_a & src_b;
         4'd3:    alu_res = src_a | src_b;
         4'd4:    alu_res = src_a ^ src_b;
         4'd5:    alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
         4'd6:    alu_res = {31'd0, src_a < src_b};
         4'd7:    alu_res = src_a << src_b[4:0];
         4'd8:    alu_res = src_a >> src_b[4:0];
         4'd9:    alu_res = $signed(src_a) >>> src_b[4:0];
         4'd10:   alu_res = src_b;
         default: alu_res = 32'd0;
      endcase
   end

   // Branch compare always uses the forwarded register values, never the immediate
   always_comb begin
      taken = 1'b0;
      case (bus.funct3E)
         3'b000:  taken = (src_a == fwd_b);
         3'b001:  taken = (src_a != fwd_b);
         3'b100:  taken = ($signed(src_a) <  $signed(fwd_b));
         3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
         3'b110:  taken = (src_a <  fwd_b);
         3'b111:  taken = (src_a >= fwd_b);
         default: taken = 1'b0;
      endcase
   end

   assign bus.PCTargetE = bus.PCE + bus.ImmExtE;
   assign bus.PCSrcE    = ~bus.MulDivE & ((bus.BranchE & taken) | bus.JumpE);
   // Reset dominates: no stall is requested while the stage is being cleared
   assign bus.BusyE     = busy & ~rst;

   // Divider magnitudes taken from the forwarded values at accept; funct3[0]=0 means signed
   assign div_signed = ~bus.funct3E[0];
   assign a_mag = (div_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
   assign b_mag = (div_signed && fwd_b[31]) ? (32'd0 - fwd_b) : fwd_b;

   // Sign/zero extension to 64 bits makes one unsigned 64-bit product serve all four MUL variants
   assign a64 = {{32{a_q[31] & (f3_q[1:0] != 2'b11)}}, a_q};
   assign b64 = {{32{b_q[31] & ~f3_q[1]}}, b_q};

   assign shifted = {rem_q, quo_q[31]};
   assign diff    = shifted - {2'b00, dvs_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d = a_q;  b_d = b_q;  f3_d = f3_q;
      rw_d = rw_q;  mw_d = mw_q;  rs_d = rs_q;  rd_d = rd_q;  pc4_d = pc4_q;
      prod_d = prod_q;
      rem_d = rem_q;  quo_d = quo_q;  dvs_d = dvs_q;
      busy  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.MulDivE) begin
               busy  = 1'b1;
               a_d   = src_a;
               b_d   = fwd_b;
               f3_d  = bus.funct3E;
               rw_d  = bus.RegWriteE;
               mw_d  = bus.MemWriteE;
               rs_d  = bus.ResultSrcE;
               rd_d  = bus.RD_E;
               pc4_d = bus.PCPlus4E;
               cnt_d = 5'd31;
               rem_d = 33'd0;
               quo_d = a_mag;
               dvs_d = b_mag;
               state_d = bus.funct3E[2] ? S_DIV : S_MUL;
            end
         end
         S_MUL: begin
            busy    = 1'b1;
            prod_d  = a64 * b64;
            state_d = S_DONE;
         end
         S_DIV: begin
            busy = 1'b1;
            // restoring step: keep the trial difference only if it did not go negative
            if (!diff[33]) begin
               rem_d = diff[32:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = shifted[32:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            if (cnt_q == 5'd0) state_d = S_DONE;
            else               cnt_d   = cnt_q - 5'd1;
         end
         default: begin
            // DONE: held inputs still carry MulDivE=1, so always drop back to IDLE
            state_d = S_IDLE;
         end
      endcase
   end

   // Sign fix-up and the architectural divide-by-zero results
   always_comb begin
      q_fix = (~f3_q[0] && (a_q[31] ^ b_q[31])) ? (32'd0 - quo_q) : quo_q;
      r_fix = (~f3_q[0] && a_q[31]) ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
      if (b_q == 32'd0) begin
         q_fix = 32'hFFFF_FFFF;
         r_fix = a_q;
      end
      case (f3_q)
         3'b000:          mop_res = prod_q[31:0];
         3'b001, 3'b010,
         3'b011:          mop_res = prod_q[63:32];
         3'b100, 3'b101:  mop_res = q_fix;
         default:         mop_res = r_fix;
      endcase
   end

   always_comb begin
      regwrite_m_d   = bus.RegWriteE;
      memwrite_m_d   = bus.MemWriteE;
      resultsrc_m_d  = bus.ResultSrcE;
      rd_m_d         = bus.RD_E;
      funct3_m_d     = bus.funct3E;
      pcplus4_m_d    = bus.PCPlus4E;
      writedata_m_d  = fwd_b;
      alu_result_m_d = alu_res;
      if (busy) begin
         // bubble; the data fields simply hold
         regwrite_m_d   = 1'b0;
         memwrite_m_d   = 1'b0;
         resultsrc_m_d  = 1'b0;
         rd_m_d         = 5'd0;
         funct3_m_d     = funct3_m_q;
         pcplus4_m_d    = pcplus4_m_q;
         writedata_m_d  = writedata_m_q;
         alu_result_m_d = alu_result_m_q;
      end else if (state_q == S_DONE) begin
         regwrite_m_d   = rw_q;
         memwrite_m_d   = mw_q;
         resultsrc_m_d  = rs_q;
         rd_m_d         = rd_q;
         funct3_m_d     = f3_q;
         pcplus4_m_d    = pc4_q;
         writedata_m_d  = b_q;
         alu_result_m_d = mop_res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;  cnt_q <= 5'd0;
         a_q <= '0;  b_q <= '0;  f3_q <= '0;
         rw_q <= 1'b0;  mw_q <= 1'b0;  rs_q <= 1'b0;  rd_q <= '0;  pc4_q <= '0;
         prod_q <= '0;  rem_q <= '0;  quo_q <= '0;  dvs_q <= '0;
         regwrite_m_q <= 1'b0;  memwrite_m_q <= 1'b0;  resultsrc_m_q <= 1'b0;
         rd_m_q <= '0;  funct3_m_q <= '0;  pcplus4_m_q <= '0;
         writedata_m_q <= '0;  alu_result_m_q <= '0;
      end else begin
         state_q <= state_d;  cnt_q <= cnt_d;
         a_q <= a_d;  b_q <= b_d;  f3_q <= f3_d;
         rw_q <= rw_d;  mw_q <= mw_d;  rs_q <= rs_d;  rd_q <= rd_d;  pc4_q <= pc4_d;
         prod_q <= prod_d;  rem_q <= rem_d;  quo_q <= quo_d;  dvs_q <= dvs_d;
         regwrite_m_q <= regwrite_m_d;  memwrite_m_q <= memwrite_m_d;  resultsrc_m_q <= resultsrc_m_d;
         rd_m_q <= rd_m_d;  funct3_m_q <= funct3_m_d;  pcplus4_m_q <= pcplus4_m_d;
         writedata_m_q <= writedata_m_d;  alu_result_m_q <= alu_result_m_d;
      end
   end

   assign bus.RegWriteM   = regwrite_m_q;
   assign bus.MemWriteM   = memwrite_m_q;
   assign bus.ResultSrcM  = resultsrc_m_q;
   assign bus.RD_M        = rd_m_q;
   assign bus.funct3M     = funct3_m_q;
   assign bus.PCPlus4M    = pcplus4_m_q;
   assign bus.WriteDataM  = writedata_m_q;
   assign bus.ALU_ResultM = alu_result_m_q;
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle
//   Directed-vector bench for execute_cycle: reset, ALU/forwarding, branch
//   compare, MUL/DIV latency and results, divide corner cases, mid-op reset.
module tb_execute_cycle;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;

   execute_cycle_if bus ();

   execute_cycle dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %-14s got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %-14s 0x%08h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.RegWriteE = 1'b0;  bus.MemWriteE = 1'b0;  bus.ResultSrcE = 1'b0;
      bus.BranchE = 1'b0;    bus.JumpE = 1'b0;      bus.ALUSrcE = 1'b0;
      bus.MulDivE = 1'b0;    bus.ALUControlE = 4'd0; bus.funct3E = 3'd0;
      bus.RD_E = 5'd0;       bus.RD1E = 32'd0;      bus.RD2E = 32'd0;
      bus.ImmExtE = 32'd0;   bus.PCE = 32'd0;       bus.PCPlus4E = 32'd0;
      bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00; bus.ResultW = 32'd0;
   endtask

   task automatic alu_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
      bus.MulDivE = 1'b0;  bus.ALUControlE = ctl;  bus.RD1E = a;  bus.RD2E = b;
      bus.ALUSrcE = 1'b0;  bus.RegWriteE = 1'b1;
   endtask

   // Runs a held M-op to completion; returns busy-cycle count and whether any bubble leaked
   task automatic run_mop(output int busy_cnt, output logic bubble_bad);
      busy_cnt   = 0;
      bubble_bad = 1'b0;
      #1;
      for (int i = 0; i < 50; i++) begin
         if (!bus.BusyE) break;
         busy_cnt++;
         step();
         if (bus.RegWriteM || bus.MemWriteM || bus.ResultSrcM || bus.RD_M != 5'd0)
            bubble_bad = 1'b1;
      end
      step();
   endtask

   task automatic mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input int exp_busy, input logic [31:0] exp_res, input string tag);
      int   bc;
      logic bb;
      bus.MulDivE = 1'b1;  bus.funct3E = f3;  bus.RD1E = a;  bus.RD2E = b;
      bus.RegWriteE = 1'b1;  bus.RD_E = 5'd7;  bus.ALUSrcE = 1'b0;
      run_mop(bc, bb);
      check({tag, "_busy"}, bc, exp_busy);
      check({tag, "_bubble"}, {31'd0, bb}, 32'd0);
      check(tag, bus.ALU_ResultM, exp_res);
   endtask

   initial begin
      idle_inputs();
      // reset with garbage on every input, including an M-op request
      rst = 1'b1;
      bus.RegWriteE = 1'b1;  bus.MemWriteE = 1'b1;  bus.ResultSrcE = 1'b1;
      bus.MulDivE = 1'b1;    bus.funct3E = 3'b100;  bus.RD_E = 5'd31;
      bus.RD1E = 32'hDEAD_BEEF;  bus.RD2E = 32'h1234_5678;  bus.PCPlus4E = 32'hCAFE_0004;
      step();
      step();
      check("rst_regwrite", {31'd0, bus.RegWriteM}, 32'd0);
      check("rst_rd", {27'd0, bus.RD_M}, 32'd0);
      check("rst_alu", bus.ALU_ResultM, 32'd0);
      check("rst_wdata", bus.WriteDataM, 32'd0);
      check("rst_pc4", bus.PCPlus4M, 32'd0);
      check("rst_busy", {31'd0, bus.BusyE}, 32'd0);
      rst = 1'b0;
      idle_inputs();

      // add 5+7
      alu_op(4'd0, 32'd5, 32'd7);
      bus.RD_E = 5'd3;  bus.PCPlus4E = 32'h104;
      #1;
      check("add_busy", {31'd0, bus.BusyE}, 32'd0);
      step();
      check("add", bus.ALU_ResultM, 32'd12);
      check("add_regwrite", {31'd0, bus.RegWriteM}, 32'd1);
      check("add_rd", {27'd0, bus.RD_M}, 32'd3);
      check("add_pc4", bus.PCPlus4M, 32'h104);

      // forward ALU_ResultM into A with immediate B
      alu_op(4'd0, 32'h10, 32'd0);
      step();
      check("pre_fwd", bus.ALU_ResultM, 32'h10);
      alu_op(4'd0, 32'hDEAD, 32'h55);
      bus.ForwardAE = 2'b10;  bus.ALUSrcE = 1'b1;  bus.ImmExtE = 32'd4;
      step();
      check("fwd_a_m", bus.ALU_ResultM, 32'h14);
      check("fwd_wdata", bus.WriteDataM, 32'h55);

      // forward ResultW into B, sub
      alu_op(4'd1, 32'h100, 32'hFFFF);
      bus.ForwardAE = 2'b00;  bus.ForwardBE = 2'b01;  bus.ResultW = 32'h30;
      step();
      check("fwd_b_w", bus.ALU_ResultM, 32'hD0);
      check("fwd_b_wdata", bus.WriteDataM, 32'h30);
      bus.ForwardBE = 2'b00;

      // shifts and compares
      alu_op(4'd9, 32'h8000_0000, 32'd0);
      bus.ALUSrcE = 1'b1;  bus.ImmExtE = 32'd4;
      step();
      check("sra", bus.ALU_ResultM, 32'hF800_0000);
      alu_op(4'd8, 32'h8000_0000, 32'd0);
      bus.ALUSrcE = 1'b1;  bus.ImmExtE = 32'd4;
      step();
      check("srl", bus.ALU_ResultM, 32'h0800_0000);
      alu_op(4'd5, 32'hFFFF_FFFF, 32'd1);
      step();
      check("slt", bus.ALU_ResultM, 32'd1);
      alu_op(4'd6, 32'hFFFF_FFFF, 32'd1);
      step();
      check("sltu", bus.ALU_ResultM, 32'd0);

      // branches: blt taken, bltu not
      alu_op(4'd1, 32'hFFFF_FFFF, 32'd1);
      bus.RegWriteE = 1'b0;  bus.BranchE = 1'b1;  bus.funct3E = 3'b100;
      bus.PCE = 32'h100;  bus.ImmExtE = 32'h20;
      #1;
      check("blt_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
      check("blt_target", bus.PCTargetE, 32'h120);
      bus.funct3E = 3'b110;
      #1;
      check("bltu_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);
      bus.BranchE = 1'b0;  bus.JumpE = 1'b1;
      #1;
      check("jal_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
      bus.JumpE = 1'b0;
      step();

      // multiplies, back to back
      mop(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0000, "mulh");
      check("mulh_rd", {27'd0, bus.RD_M}, 32'd7);
      check("mulh_regwr", {31'd0, bus.RegWriteM}, 32'd1);
      mop(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, "mulhu");
      mop(3'b000, 32'h1234_5678, 32'h10, 2, 32'h2345_6780, "mul");

      // divides
      mop(3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, "div");
      mop(3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, "rem");
      mop(3'b101, 32'h1234, 32'd0, 33, 32'hFFFF_FFFF, "divu_0");
      mop(3'b111, 32'h1234, 32'd0, 33, 32'h0000_1234, "remu_0");
      mop(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, "div_ovf");
      mop(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, "rem_ovf");

      // reset during divide iteration 10
      bus.MulDivE = 1'b1;  bus.funct3E = 3'b100;  bus.RD1E = 32'd1000;  bus.RD2E = 32'd3;
      bus.RegWriteE = 1'b1;  bus.RD_E = 5'd9;
      #1;
      step();
      repeat (9) step();
      check("mid_busy", {31'd0, bus.BusyE}, 32'd1);
      rst = 1'b1;
      step();
      check("mrst_busy", {31'd0, bus.BusyE}, 32'd0);
      check("mrst_regwr", {31'd0, bus.RegWriteM}, 32'd0);
      check("mrst_alu", bus.ALU_ResultM, 32'd0);
      rst = 1'b0;
      alu_op(4'd4, 32'hF0, 32'hFF);
      bus.RD_E = 5'd4;
      #1;
      check("post_busy", {31'd0, bus.BusyE}, 32'd0);
      step();
      check("post_xor", bus.ALU_ResultM, 32'h0F);
      check("post_rd", {27'd0, bus.RD_M}, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
